// File: rtl/a_demux_serial_pv_if.sv
// Bit-sampler / word-consumer bundle for a_demux_serial_pv.
// master = sampler+consumer side, slave = the deserialiser.
interface a_demux_serial_pv_if #(
    parameter int unsigned DATA_W = 8
);
    logic              clk_rcpt;
    logic              r_di;
    logic              r_sync;
    logic              r_rdy_i;
    logic              r_ovr_clr_i;
    logic [DATA_W-1:0] r_q;
    logic              r_dv_o;
    logic              r_ovr_o;
    logic              r_perr_o;

    modport master (
        output clk_rcpt, r_di, r_sync, r_rdy_i, r_ovr_clr_i,
        input  r_q, r_dv_o, r_ovr_o, r_perr_o
    );

    modport slave (
        input  clk_rcpt, r_di, r_sync, r_rdy_i, r_ovr_clr_i,
        output r_q, r_dv_o, r_ovr_o, r_perr_o
    );
endinterface

// File: rtl/a_demux_serial_pv.sv
// Serial-to-parallel deserialiser with holding register, resync and sticky overrun.
// Define A_DEMUX_SERIAL_PV_PARITY_EN to append and check one parity bit per frame.
module a_demux_serial_pv #(
    parameter int unsigned DATA_W     = 8,
    parameter bit          MSB_FIRST  = 1'b0,
    parameter bit          ODD_PARITY = 1'b0
) (
    input  logic                 clk_ref,
    input  logic                 rst_n,
    a_demux_serial_pv_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
`ifdef A_DEMUX_SERIAL_PV_PARITY_EN
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W);
`else
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
`endif

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_eff;
    logic [CNT_W-1:0]  pos;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] sh_base;
    logic [DATA_W-1:0] sh_merged;
    logic              done;
    logic              load;
    logic              ovr_set;
    logic [DATA_W-1:0] q;
    logic              dv;
    logic              ovr;
    logic              perr;
    logic              perr_next;

    // r_sync restarts the frame on this edge, so a coincident strobe becomes bit 0
    always_comb begin
        cnt_eff   = bus.r_sync ? '0 : cnt;
        sh_base   = bus.r_sync ? '0 : sh;
        pos       = MSB_FIRST ? (CNT_W'(DATA_W - 1) - cnt_eff) : cnt_eff;
        sh_merged = sh_base;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (bus.clk_rcpt && (cnt_eff < CNT_W'(DATA_W)) && (pos == CNT_W'(i)))
                sh_merged[i] = bus.r_di;
        end
        done    = bus.clk_rcpt && (cnt_eff == LAST);
        load    = done && (!dv || bus.r_rdy_i);
        ovr_set = done && dv && !bus.r_rdy_i;
    end

`ifdef A_DEMUX_SERIAL_PV_PARITY_EN
    // at completion the strobed bit is the parity bit; data is already in sh_base
    always_comb begin
        perr_next = (^sh_base) ^ bus.r_di ^ ODD_PARITY;
    end
`else
    always_comb begin
        perr_next = 1'b0;
    end
`endif

    always_ff @(posedge clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sh   <= '0;
            q    <= '0;
            dv   <= 1'b0;
            ovr  <= 1'b0;
            perr <= 1'b0;
        end else begin
            if (done) begin
                cnt <= '0;
                sh  <= '0;
            end else if (bus.clk_rcpt) begin
                cnt <= cnt_eff + CNT_W'(1);
                sh  <= sh_merged;
            end else begin
                cnt <= cnt_eff;
                sh  <= sh_base;
            end

            if (load) begin
                q    <= sh_merged;
                dv   <= 1'b1;
                perr <= perr_next;
            end else if (dv && bus.r_rdy_i) begin
                dv <= 1'b0;
            end

            if (ovr_set)
                ovr <= 1'b1;
            else if (bus.r_ovr_clr_i)
                ovr <= 1'b0;
        end
    end

    assign bus.r_q      = q;
    assign bus.r_dv_o   = dv;
    assign bus.r_ovr_o  = ovr;
`ifdef A_DEMUX_SERIAL_PV_PARITY_EN
    assign bus.r_perr_o = perr;
`else
    assign bus.r_perr_o = 1'b0;
`endif
endmodule

// File: tb/tb_a_demux_serial_pv.sv
// Directed bench: LSB-first and MSB-first instances fed the same bit stream.
module tb_a_demux_serial_pv;
    logic clk;
    logic rst_n;
    logic strobe, di, sync, rdy, clr;
    int   checks;
    int   failures;

    a_demux_serial_pv_if #(.DATA_W(8)) if_lsb ();
    a_demux_serial_pv_if #(.DATA_W(8)) if_msb ();

    assign if_lsb.clk_rcpt    = strobe;
    assign if_lsb.r_di        = di;
    assign if_lsb.r_sync      = sync;
    assign if_lsb.r_rdy_i     = rdy;
    assign if_lsb.r_ovr_clr_i = clr;
    assign if_msb.clk_rcpt    = strobe;
    assign if_msb.r_di        = di;
    assign if_msb.r_sync      = sync;
    assign if_msb.r_rdy_i     = rdy;
    assign if_msb.r_ovr_clr_i = clr;

    a_demux_serial_pv #(.DATA_W(8), .MSB_FIRST(1'b0), .ODD_PARITY(1'b0)) u_lsb (
        .clk_ref (clk),
        .rst_n   (rst_n),
        .bus     (if_lsb.slave)
    );

    a_demux_serial_pv #(.DATA_W(8), .MSB_FIRST(1'b1), .ODD_PARITY(1'b0)) u_msb (
        .clk_ref (clk),
        .rst_n   (rst_n),
        .bus     (if_msb.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bit_in(input logic b);
        strobe = 1'b1;
        di     = b;
        @(negedge clk);
        strobe = 1'b0;
        di     = 1'b0;
    endtask

    // data bits LSB of d first, followed by an even-parity bit when parity is compiled in
    task automatic frame(input logic [7:0] d);
        for (int i = 0; i < 8; i++) bit_in(d[i]);
`ifdef A_DEMUX_SERIAL_PV_PARITY_EN
        bit_in(^d);
`endif
    endtask

    initial begin
        checks = 0; failures = 0;
        strobe = 1'b0; di = 1'b0; sync = 1'b0; rdy = 1'b1; clr = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst_q",    32'(if_lsb.r_q),    32'h00);
        check("rst_dv",   32'(if_lsb.r_dv_o), 32'h0);
        check("rst_ovr",  32'(if_lsb.r_ovr_o), 32'h0);
        check("rst_perr", 32'(if_lsb.r_perr_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // basic word, both bit orders, accepted after one cycle
        frame(8'h4D);
        check("t1_dv",     32'(if_lsb.r_dv_o), 32'h1);
        check("t1_q_lsb",  32'(if_lsb.r_q),    32'h4D);
        check("t1_q_msb",  32'(if_msb.r_q),    32'hB2);
        check("t1_ovr",    32'(if_lsb.r_ovr_o), 32'h0);
        check("t1_perr",   32'(if_lsb.r_perr_o), 32'h0);
        @(negedge clk);
        check("t1_dv_drop", 32'(if_lsb.r_dv_o), 32'h0);
        check("t1_q_hold",  32'(if_lsb.r_q),    32'h4D);

        // overrun while consumer stalled
        rdy = 1'b0;
        frame(8'h55);
        check("t3_dv1",    32'(if_lsb.r_dv_o), 32'h1);
        check("t3_q1",     32'(if_lsb.r_q),    32'h55);
        check("t3_ovr0",   32'(if_lsb.r_ovr_o), 32'h0);
        frame(8'hAA);
        check("t3_q_keep",   32'(if_lsb.r_q),    32'h55);
        check("t3_qm_keep",  32'(if_msb.r_q),    32'hAA);
        check("t3_dv_keep",  32'(if_lsb.r_dv_o), 32'h1);
        check("t3_ovr_set",  32'(if_lsb.r_ovr_o), 32'h1);
        check("t3_ovrm_set", 32'(if_msb.r_ovr_o), 32'h1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("t3_ovr_clr",  32'(if_lsb.r_ovr_o), 32'h0);
        check("t3_dv_still", 32'(if_lsb.r_dv_o), 32'h1);
        rdy = 1'b1;
        @(negedge clk);
        check("t3_dv_acc",   32'(if_lsb.r_dv_o), 32'h0);

        // resync mid-frame with coincident strobe
        for (int i = 0; i < 5; i++) bit_in(1'b1);
        check("t4_no_word", 32'(if_lsb.r_dv_o), 32'h0);
        sync = 1'b1;
        bit_in(1'b1);
        sync = 1'b0;
        for (int i = 0; i < 6; i++) bit_in(1'b0);
        check("t4_dv_early", 32'(if_lsb.r_dv_o), 32'h0);
        bit_in(1'b0);
`ifdef A_DEMUX_SERIAL_PV_PARITY_EN
        check("t4_dv_prepar", 32'(if_lsb.r_dv_o), 32'h0);
        bit_in(1'b1);
`endif
        check("t4_dv",    32'(if_lsb.r_dv_o), 32'h1);
        check("t4_q_lsb", 32'(if_lsb.r_q),    32'h01);
        check("t4_q_msb", 32'(if_msb.r_q),    32'h80);
        @(negedge clk);

`ifdef A_DEMUX_SERIAL_PV_PARITY_EN
        // explicit parity bits against 8'h07 (three ones)
        for (int i = 0; i < 8; i++) bit_in(i < 3);
        bit_in(1'b1);
        check("t5_perr_ok", 32'(if_lsb.r_perr_o), 32'h0);
        check("t5_dv_ok",   32'(if_lsb.r_dv_o),   32'h1);
        check("t5_q_ok",    32'(if_lsb.r_q),      32'h07);
        for (int i = 0; i < 8; i++) bit_in(i < 3);
        bit_in(1'b0);
        check("t5_perr_bad", 32'(if_lsb.r_perr_o), 32'h1);
        check("t5_dv_bad",   32'(if_lsb.r_dv_o),   32'h1);
        check("t5_q_bad",    32'(if_lsb.r_q),      32'h07);
        @(negedge clk);
        check("t5_perr_hold", 32'(if_lsb.r_perr_o), 32'h1);
`endif

        // reset after 3 bits, then a clean word
        for (int i = 0; i < 3; i++) bit_in(1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_q",    32'(if_lsb.r_q),      32'h00);
        check("t6_rst_qm",   32'(if_msb.r_q),      32'h00);
        check("t6_rst_dv",   32'(if_lsb.r_dv_o),   32'h0);
        check("t6_rst_ovr",  32'(if_lsb.r_ovr_o),  32'h0);
        check("t6_rst_perr", 32'(if_lsb.r_perr_o), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame(8'hF0);
        check("t6_q_lsb", 32'(if_lsb.r_q),    32'hF0);
        check("t6_q_msb", 32'(if_msb.r_q),    32'h0F);
        check("t6_dv",    32'(if_lsb.r_dv_o), 32'h1);
        check("t6_perr",  32'(if_lsb.r_perr_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
